// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
package router_pkg;

    // Controller states; 3-bit encoding shared with anything decoding the state.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    // Header address value that names no output port.
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Pick one per-port flag by address; the invalid address selects nothing.
    function automatic logic sel_flag(input logic [2:0] flags, input logic [1:0] idx);
        logic res;
        case (idx)
            2'd0:    res = flags[0];
            2'd1:    res = flags[1];
            2'd2:    res = flags[2];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Packet-sequencing controller for the 1x3 router: decodes the header
// address, waits for the destination FIFO to drain, paces header/payload/
// parity writes, stalls on FIFO-full and aborts on a destination soft reset.
module router_ctrl_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [1:0] dest_addr
);

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_reg;
    logic [1:0] sel_idx;
    logic       sel_empty;
    logic       abort;
    logic       addr_load;

    // While decoding, the incoming header picks the port; afterwards the latched one does.
    assign sel_idx   = (state == DECODE_ADDRESS) ? data_in : addr_reg;
    assign sel_empty = sel_flag({fifo_empty_2, fifo_empty_1, fifo_empty_0}, sel_idx);

    // A soft reset only matters for the port currently being written.
    assign abort = (state != DECODE_ADDRESS) &&
                   sel_flag({soft_reset_2, soft_reset_1, soft_reset_0}, addr_reg);

    // Capture the header address only when a valid header is accepted.
    assign addr_load = (state == DECODE_ADDRESS) &&
                       ((next_state == LOAD_FIRST_DATA) || (next_state == WAIT_TILL_EMPTY));

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= DECODE_ADDRESS;
        else         state <= next_state;
    end

    // Destination address register.
    always_ff @(posedge clk) begin
        if (!resetn)        addr_reg <= ADDR_INVALID;
        else if (addr_load) addr_reg <= data_in;
    end

    // Next-state logic; abort overrides every normal transition.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = DECODE_ADDRESS;
        end else begin
            unique case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && (data_in != ADDR_INVALID))
                        next_state = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid) next_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) next_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        next_state = DECODE_ADDRESS;
                    else if (low_pkt_valid) next_state = LOAD_PARITY;
                    else                    next_state = LOAD_DATA;
                end
                LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty) next_state = LOAD_FIRST_DATA;
                end
                default: next_state = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        laf_state     = (state == LOAD_AFTER_FULL);
        full_state    = (state == FIFO_FULL_STATE);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
        busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
        dest_addr     = addr_reg;
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_router_ctrl_fsm;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy;
    logic [1:0] dest_addr;

    int n_chk  = 0;
    int n_pass = 0;

    router_ctrl_fsm dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .dest_addr(dest_addr)
    );

    always #5 clk = ~clk;

    // Model phases named by the packet's progress, independent of RTL encoding.
    localparam string PH_NAME [8] = '{"idle", "header", "payload", "stalled",
                                      "resume", "parity", "check", "waiting"};
    int m_ph;        // index into PH_NAME
    int m_addr;      // latched destination, 3 = none
    int trace_q[$];  // recent phases, for directed trace checks

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (model phase %s, t=%0t)",
                      tag, obs, exp, PH_NAME[m_ph], $time);
    endtask

    function automatic bit empty_of(input int p);
        if (p == 0) return fifo_empty_0;
        if (p == 1) return fifo_empty_1;
        if (p == 2) return fifo_empty_2;
        return 1'b0;
    endfunction

    function automatic bit sreset_of(input int p);
        if (p == 0) return soft_reset_0;
        if (p == 1) return soft_reset_1;
        if (p == 2) return soft_reset_2;
        return 1'b0;
    endfunction

    // Apply the current inputs for one clock and compare all outputs afterward.
    task automatic tick();
        int nph, naddr;
        nph = m_ph; naddr = m_addr;
        if (!resetn) begin
            nph = 0; naddr = 3;
        end else if (m_ph != 0 && sreset_of(m_addr)) begin
            nph = 0;
        end else begin
            case (PH_NAME[m_ph])
                "idle":    if (pkt_valid && data_in != 3) begin
                               naddr = data_in;
                               nph = empty_of(data_in) ? 1 : 7;
                           end
                "header":  nph = 2;
                "payload": nph = fifo_full ? 3 : (!pkt_valid ? 5 : 2);
                "stalled": nph = fifo_full ? 3 : 4;
                "resume":  nph = parity_done ? 0 : (low_pkt_valid ? 5 : 2);
                "parity":  nph = 6;
                "check":   nph = fifo_full ? 3 : 0;
                "waiting": nph = empty_of(m_addr) ? 1 : 7;
                default:   nph = 0;
            endcase
        end
        @(posedge clk);
        #1;
        m_ph = nph; m_addr = naddr;
        trace_q.push_back(m_ph);
        chk("detect_add",  detect_add,  m_ph == 0);
        chk("lfd_state",   lfd_state,   m_ph == 1);
        chk("ld_state",    ld_state,    m_ph == 2);
        chk("full_state",  full_state,  m_ph == 3);
        chk("laf_state",   laf_state,   m_ph == 4);
        chk("rst_int_reg", rst_int_reg, m_ph == 6);
        chk("write_enb",   write_enb_reg, (m_ph == 2) || (m_ph == 4) || (m_ph == 5));
        chk("busy",        busy,        !(m_ph == 0 || m_ph == 2));
        chk("dest_addr",   dest_addr,   m_addr);
    endtask

    task automatic idle_inputs();
        resetn = 1; pkt_valid = 0; data_in = 0; fifo_full = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        parity_done = 0; low_pkt_valid = 0;
    endtask

    // Compare the last n recorded phases against an expected sequence.
    task automatic chk_trace(input string tag, input int exp[$]);
        int base;
        base = trace_q.size() - exp.size();
        for (int i = 0; i < exp.size(); i++)
            chk(tag, (base + i >= 0) ? trace_q[base + i] : -1, exp[i]);
    endtask

    initial begin
        m_ph = 0; m_addr = 3;
        idle_inputs();
        resetn = 0;
        tick(); tick();
        // Reset state, checked against fixed values as well as the model.
        chk("rst_detect", detect_add, 1);
        chk("rst_dest",   dest_addr, 3);
        chk("rst_busy",   busy, 0);
        resetn = 1;

        // Address 1, empty destination, 4-byte payload.
        trace_q.delete();
        pkt_valid = 1; data_in = 1; tick();          // -> header
        tick();                                       // -> payload
        tick(); tick(); tick();                        // payload x4 total
        pkt_valid = 0; tick();                        // parity byte -> parity
        tick(); tick();                               // check, idle
        chk_trace("trace_pkt", '{1, 2, 2, 2, 2, 5, 6, 0});
        chk("dest_pkt", dest_addr, 1);

        // Address 2 with a non-empty FIFO for five cycles.
        trace_q.delete();
        fifo_empty_2 = 0; pkt_valid = 1; data_in = 2;
        repeat (5) tick();
        fifo_empty_2 = 1; tick();
        chk_trace("trace_wte", '{7, 7, 7, 7, 7, 1});
        tick();                                       // payload
        // Full for three cycles mid-payload.
        trace_q.delete();
        fifo_full = 1; tick(); tick(); tick();
        fifo_full = 0; tick(); tick();
        chk_trace("trace_ffs", '{3, 3, 3, 4, 2});
        // Full as pkt_valid falls; exit with low_pkt_valid.
        trace_q.delete();
        fifo_full = 1; pkt_valid = 0; tick();
        fifo_full = 0; tick();
        low_pkt_valid = 1; tick(); low_pkt_valid = 0;
        tick(); tick();
        chk_trace("trace_laf_lp", '{3, 4, 5, 6, 0});

        // Same exit with parity_done: straight back to idle.
        trace_q.delete();
        pkt_valid = 1; data_in = 0; tick(); tick();
        fifo_full = 1; tick(); fifo_full = 0; tick();
        parity_done = 1; low_pkt_valid = 1; pkt_valid = 0; tick();
        parity_done = 0; low_pkt_valid = 0;
        chk_trace("trace_laf_pd", '{1, 2, 3, 4, 0});

        // Invalid address never leaves idle and leaves dest_addr alone.
        pkt_valid = 1; data_in = 3; tick(); tick();
        chk("inv_busy", busy, 0);
        chk("inv_dest", dest_addr, 0);

        // Soft reset in the wait state.
        fifo_empty_0 = 0; data_in = 0; tick(); tick();
        pkt_valid = 0; soft_reset_0 = 1; tick(); soft_reset_0 = 0;
        chk("sr_wte_detect", detect_add, 1);
        fifo_empty_0 = 1;

        // Synchronous reset in the middle of payload.
        pkt_valid = 1; data_in = 2; tick(); tick();
        resetn = 0; tick(); resetn = 1;
        chk("rst_ld_dest", dest_addr, 3);
        pkt_valid = 0; tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            resetn        = ($urandom_range(0, 199) != 0);
            pkt_valid     = ($urandom_range(0, 9) < 7);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 9) < 2);
            fifo_empty_0  = ($urandom_range(0, 9) < 6);
            fifo_empty_1  = ($urandom_range(0, 9) < 6);
            fifo_empty_2  = ($urandom_range(0, 9) < 6);
            soft_reset_0  = ($urandom_range(0, 39) == 0);
            soft_reset_1  = ($urandom_range(0, 39) == 0);
            soft_reset_2  = ($urandom_range(0, 39) == 0);
            parity_done   = ($urandom_range(0, 9) < 2);
            low_pkt_valid = ($urandom_range(0, 9) < 3);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
